// File: rtl/inst_rom_loader.sv
// Boot-time instruction ROM: packs a little-endian byte stream into words,
// then serves registered instruction fetches until the core halts.
module inst_rom_loader #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] START_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [7:0]    load_byte,
    input  logic          load_last,
    output logic          load_ready,
    output logic          go,
    output logic [31:0]   start_pc,
    input  logic          read_enable_cpu,
    input  logic [31:0]   next_inst_addr,
    output logic [31:0]   inst,
    input  logic          halt,
    output logic [AW:0]   words_loaded,
    output logic          load_err
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] mem [DEPTH_WORDS];
    logic [AW:0] wptr;
    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
    logic [31:0] wdata;
    logic [31:0] off;
    logic [31:0] idx;
    logic [31:0] inst_next;
    logic        accept;
    logic        full;
    logic        wr_en;
    logic        hit;

    assign start_pc     = START_PC;
    assign words_loaded = wptr;

    assign accept = load_valid && load_ready;
    assign full   = (wptr == (AW+1)'(DEPTH_WORDS));
    assign wr_en  = !reset && accept && !full && ((byte_cnt == 2'd3) || load_last);
    // Buffer is cleared after every word write, so unfilled upper lanes read as zero.
    assign wdata  = word_buf | ({24'h0, load_byte} << {byte_cnt, 3'b000});

    // Address below START_PC wraps to a huge index and misses.
    assign off = next_inst_addr - START_PC;
    assign idx = off >> 2;
    assign hit = (next_inst_addr[1:0] == 2'b00) && (idx < 32'(wptr));

    always_comb begin
        state_next = state;
        inst_next  = inst;
        case (state)
            ST_LOAD: begin
                if (accept && load_last)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_HALTED;
                    inst_next  = NOP_INST;
                end else if (read_enable_cpu) begin
                    inst_next = hit ? mem[idx[AW-1:0]] : NOP_INST;
                end
            end
            ST_HALTED: begin
                inst_next = NOP_INST;
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_LOAD;
            load_ready <= 1'b0;
            go         <= 1'b0;
            inst       <= NOP_INST;
            wptr       <= '0;
            byte_cnt   <= 2'd0;
            word_buf   <= 32'h0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_next;
            load_ready <= (state_next == ST_LOAD);
            go         <= (state_next == ST_RUN);
            inst       <= inst_next;
            if (accept) begin
                if (full) begin
                    load_err <= 1'b1;
                end else if (wr_en) begin
                    wptr     <= wptr + 1'b1;
                    byte_cnt <= 2'd0;
                    word_buf <= 32'h0;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                    word_buf <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: dut0 uses defaults, dut1 is a
// 4-word ROM based at 0x100 for overflow and offset-address cases.
module tb_inst_rom_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int S_INST = 0, S_GO = 1, S_RDY = 2, S_WL = 3, S_ERR = 4, S_SPC = 5;

    typedef struct {
        int          cyc;
        int          d;
        int          sig;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    chk_t        sb[$];

    logic        rst [2];
    logic        lv  [2];
    logic [7:0]  lb  [2];
    logic        ll  [2];
    logic        re  [2];
    logic [31:0] addr[2];
    logic        hlt [2];
    logic        lr  [2];
    logic        go_o[2];
    logic [31:0] spc [2];
    logic [31:0] inst_o[2];
    logic        err [2];
    logic [8:0]  wl0;
    logic [2:0]  wl1;

    inst_rom_loader dut0 (
        .clk(clk), .reset(rst[0]), .load_valid(lv[0]), .load_byte(lb[0]),
        .load_last(ll[0]), .load_ready(lr[0]), .go(go_o[0]), .start_pc(spc[0]),
        .read_enable_cpu(re[0]), .next_inst_addr(addr[0]), .inst(inst_o[0]),
        .halt(hlt[0]), .words_loaded(wl0), .load_err(err[0])
    );

    inst_rom_loader #(.DEPTH_WORDS(4), .START_PC(32'h0000_0100)) dut1 (
        .clk(clk), .reset(rst[1]), .load_valid(lv[1]), .load_byte(lb[1]),
        .load_last(ll[1]), .load_ready(lr[1]), .go(go_o[1]), .start_pc(spc[1]),
        .read_enable_cpu(re[1]), .next_inst_addr(addr[1]), .inst(inst_o[1]),
        .halt(hlt[1]), .words_loaded(wl1), .load_err(err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int d, int sig);
        case (sig)
            S_INST:  return inst_o[d];
            S_GO:    return {31'h0, go_o[d]};
            S_RDY:   return {31'h0, lr[d]};
            S_WL:    return (d == 0) ? {23'h0, wl0} : {29'h0, wl1};
            S_ERR:   return {31'h0, err[d]};
            default: return spc[d];
        endcase
    endfunction

    // Monitor: compares every scoreboard entry due after the current edge.
    always @(negedge clk) begin
        int i;
        logic [31:0] a;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                a = actual(sb[i].d, sb[i].sig);
                n_checks++;
                if (a !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s (dut%0d cyc %0d): got %08h expected %08h",
                             sb[i].name, sb[i].d, cyc, a, sb[i].exp);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic check_now(logic [31:0] a, logic [31:0] e, string name);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s (cyc %0d): got %08h expected %08h", name, cyc, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_next(int d, int sig, logic [31:0] e, string name);
        chk_t c;
        c.cyc = cyc + 1; c.d = d; c.sig = sig; c.exp = e; c.name = name;
        sb.push_back(c);
    endtask

    task automatic do_reset(int d);
        rst[d] = 1'b1;
        exp_next(d, S_GO, 0, "rst_go");
        exp_next(d, S_RDY, 0, "rst_ready");
        exp_next(d, S_INST, NOP, "rst_inst");
        exp_next(d, S_WL, 0, "rst_words");
        exp_next(d, S_ERR, 0, "rst_err");
        tick();
        rst[d] = 1'b0;
        exp_next(d, S_RDY, 1, "ready_after_rst");
        tick();
    endtask

    task automatic send_byte(int d, logic [7:0] b, logic last);
        lv[d] = 1'b1; lb[d] = b; ll[d] = last;
        tick();
        lv[d] = 1'b0; ll[d] = 1'b0;
    endtask

    task automatic fetch(int d, logic [31:0] a, logic [31:0] e, string name);
        re[d] = 1'b1; addr[d] = a;
        exp_next(d, S_INST, e, name);
        tick();
        re[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] prog1 [8];
        prog1 = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; lv[d] = 1'b0; lb[d] = 8'h0; ll[d] = 1'b0;
            re[d] = 1'b0; addr[d] = 32'h0; hlt[d] = 1'b0;
        end
        tick();

        // Two-word program, back-to-back fetches
        do_reset(0);
        exp_next(0, S_SPC, 32'h0, "start_pc_dut0");
        for (int i = 0; i < 8; i++) begin
            if (i == 6) exp_next(0, S_GO, 0, "go_before_last");
            if (i == 7) begin
                exp_next(0, S_GO, 1, "go_after_last");
                exp_next(0, S_RDY, 0, "ready_after_last");
                exp_next(0, S_WL, 2, "words_prog1");
            end
            send_byte(0, prog1[i], i == 7);
        end
        re[0] = 1'b1; addr[0] = 32'h0;
        exp_next(0, S_INST, 32'h0050_0013, "fetch_0");
        tick();
        addr[0] = 32'h4;
        exp_next(0, S_INST, 32'h0010_0093, "fetch_4");
        tick();
        re[0] = 1'b0;
        check_now(inst_o[0], 32'h0010_0093, "direct_fetch_4");
        check_now({23'h0, wl0}, 32'd2, "direct_words_prog1");
        check_now({31'h0, go_o[0]}, 32'd1, "direct_go_prog1");
        check_now(spc[0], 32'h0, "direct_start_pc_dut0");

        // Partial final word, out-of-range and unaligned fetches
        do_reset(0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) exp_next(0, S_WL, 2, "words_partial");
            send_byte(0, 8'h11 * 8'(i + 1), i == 5);
        end
        fetch(0, 32'h4, 32'h0000_6655, "fetch_partial");
        fetch(0, 32'h8, NOP, "fetch_beyond");
        fetch(0, 32'h2, NOP, "fetch_unaligned");
        fetch(0, 32'h0, 32'h4433_2211, "fetch_word0");

        // Hold inst while read_enable_cpu is low, then halt
        for (int i = 0; i < 3; i++) begin
            addr[0] = 32'h4 + 32'(i * 4);
            exp_next(0, S_INST, 32'h4433_2211, "inst_hold");
            tick();
        end
        hlt[0] = 1'b1; re[0] = 1'b1; addr[0] = 32'h4;
        exp_next(0, S_INST, NOP, "halt_wins");
        exp_next(0, S_GO, 0, "go_after_halt");
        tick();
        hlt[0] = 1'b0; re[0] = 1'b0;
        check_now({31'h0, go_o[0]}, 32'd0, "direct_go_halted");
        check_now(inst_o[0], NOP, "direct_inst_halted");
        exp_next(0, S_RDY, 0, "halted_ready");
        fetch(0, 32'h0, NOP, "fetch_halted");
        fetch(0, 32'h4, NOP, "fetch_halted2");

        // Reset mid-load discards the partial word
        do_reset(0);
        send_byte(0, 8'hAA, 1'b0);
        send_byte(0, 8'hBB, 1'b0);
        send_byte(0, 8'hCC, 1'b0);
        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                exp_next(0, S_WL, 1, "words_reload");
                exp_next(0, S_ERR, 0, "err_reload");
            end
            send_byte(0, 8'(i + 1), i == 3);
        end
        fetch(0, 32'h0, 32'h0403_0201, "fetch_reload");
        fetch(0, 32'h4, NOP, "fetch_old_word");

        // Overflow on a 4-word ROM
        do_reset(1);
        exp_next(1, S_SPC, 32'h100, "start_pc_dut1");
        for (int i = 0; i < 20; i++) begin
            if (i < 19) exp_next(1, S_RDY, 1, "ready_during_overflow");
            if (i == 15) begin
                exp_next(1, S_WL, 4, "words_full");
                exp_next(1, S_ERR, 0, "err_at_full");
            end
            if (i == 16) exp_next(1, S_ERR, 1, "err_first_drop");
            if (i == 19) begin
                exp_next(1, S_WL, 4, "words_saturated");
                exp_next(1, S_ERR, 1, "err_sticky");
                exp_next(1, S_GO, 1, "go_overflow");
            end
            send_byte(1, 8'h10 + 8'(i), i == 19);
        end
        check_now({31'h0, err[1]}, 32'd1, "direct_err_overflow");
        check_now({29'h0, wl1}, 32'd4, "direct_words_overflow");
        check_now({31'h0, go_o[1]}, 32'd1, "direct_go_overflow");
        fetch(1, 32'h100, 32'h1312_1110, "ovf_fetch_0");
        fetch(1, 32'h10C, 32'h1F1E_1D1C, "ovf_fetch_3");
        fetch(1, 32'h110, NOP, "ovf_fetch_4");
        fetch(1, 32'hFC, NOP, "ovf_below_base");

        // Non-zero START_PC with a single word
        do_reset(1);
        for (int i = 0; i < 4; i++)
            send_byte(1, 8'hA0 + 8'(i), i == 3);
        fetch(1, 32'h100, 32'hA3A2_A1A0, "base_fetch");
        check_now(inst_o[1], 32'hA3A2_A1A0, "direct_base_fetch");
        fetch(1, 32'hFC, NOP, "base_below");
        fetch(1, 32'h104, NOP, "base_beyond");

        repeat (3) tick();
        while (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s (dut%0d): check never evaluated, expected %08h",
                     sb[0].name, sb[0].d, sb[0].exp);
            void'(sb.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Boot-time instruction ROM and loader that forms the memory side of the core's fetch interface. After reset it accepts a program as a byte stream and packs the bytes little-endian into an internal word array. When the last byte arrives it asserts `go` and drives `start_pc`. While the core runs, it answers fetch requests (`next_inst_addr`, `read_enable_cpu`) with registered `inst` words. It stops serving fetches once the core raises `halt`.

## Interface
Parameters:
- `DEPTH_WORDS`, 256 — ROM capacity in 32-bit words; power of two, ≥4.
- `START_PC`, 32'h0000_0000 — byte address of word 0; driven on `start_pc`; must be 4-byte aligned.
- `NOP_INST`, 32'h0000_0013 — word returned for invalid fetches (`addi x0,x0,0`).

Ports:
- `clk` in 1 — single clock; everything is rising-edge.
- `reset` in 1 — synchronous, active-high.
- `load_valid` in 1 — loader byte is valid.
- `load_byte` in 8 — program byte; stream order is ascending address.
- `load_last` in 1 — qualifies the final byte of the program.
- `load_ready` out 1 — block can accept a byte.
- `go` out 1 — program loaded; core may run.
- `start_pc` out 32 — equals `START_PC`.
- `read_enable_cpu` in 1 — fetch request strobe.
- `next_inst_addr` in 32 — fetch byte address.
- `inst` out 32 — fetched instruction.
- `halt` in 1 — core finished.
- `words_loaded` out clog2(DEPTH_WORDS)+1 — count of words written.
- `load_err` out 1 — sticky; set when bytes overflow capacity.

## Operation
- States: LOAD, RUN, HALTED. Reset places the block in LOAD.
- LOAD:
  - `load_ready`=1. A byte is accepted on any edge where `load_valid`&&`load_ready`.
  - Accepted bytes go into a 2-bit lane counter (`byte_cnt`) and a word buffer. Lane 0 is [7:0] and lane 3 is [31:24].
  - When lane 3 is accepted, the full word is written to `mem[wptr]`, then `wptr` and `words_loaded` increment and `byte_cnt` wraps to 0.
  - If `load_last` arrives with `byte_cnt`≠3, the partial word is written with unfilled upper lanes zero, and it counts as one word.
  - If `wptr`==`DEPTH_WORDS`, further bytes are still accepted but dropped. `load_err` is set; `words_loaded` saturates at `DEPTH_WORDS`.
  - An accepted byte with `load_last`=1 moves the block to RUN.
- RUN:
  - `go`=1 and `load_ready`=0; `load_valid` is ignored.
  - For each fetch: idx = (`next_inst_addr` − `START_PC`) >> 2, 32-bit unsigned subtraction with wrap.
  - When `read_enable_cpu`=1: if `next_inst_addr[1:0]`==0 and idx < `words_loaded`, then `inst` ← `mem[idx]`; otherwise `inst` ← `NOP_INST`. An address below `START_PC` wraps to a huge idx and therefore returns NOP.
  - When `read_enable_cpu`=0, `inst` holds its value.
  - `halt`=1 in RUN moves the block to HALTED.
- HALTED:
  - `go`=0, `load_ready`=0, `inst` ← `NOP_INST`; fetches are ignored.
  - Only `reset` leaves HALTED.
- Reset:
  - `go`=0, `load_ready`=0, `inst`=`NOP_INST`, `words_loaded`=0, `load_err`=0, `byte_cnt`=0, `wptr`=0. `start_pc`=`START_PC` always.
  - Memory contents are not cleared. With `words_loaded`=0 every fetch returns NOP.
  - Reset mid-load discards the partial word and all prior words.

## Timing
- All outputs are registered.
- `load_ready` goes to 1 on the first edge with `reset`=0 after reset.
- Byte accept: one byte per cycle sustained; no bubbles between words.
- Last byte accepted at edge N:
  - The final word is written at edge N.
  - `go`=1 and `load_ready`=0 are visible after edge N.
  - A fetch is legal from edge N+1.
- Fetch latency is 1 cycle: the request sampled at edge K gives `inst` valid after edge K. Back-to-back fetches return one word per cycle.
- `halt` sampled at edge H: after edge H, `go`=0 and `inst`=NOP, even if `read_enable_cpu`=1 at H (halt wins).
- `reset` has priority over every other input on the same edge.

## Test plan
- Load 8 bytes 13 00 50 00 93 00 10 00 with `load_last` on the 8th, then fetch 0x0 and 0x4 → `inst` = 0x00500013, then 0x00100093. `words_loaded`=2; `go` rises right after the 8th-byte edge.
- Load 6 bytes ending with `load_last`, then fetch 0x4 → upper two lanes are zero and `words_loaded`=2. Fetch 0x8 → 0x00000013. Fetch 0x2 (unaligned) → NOP.
- With `DEPTH_WORDS`=4, stream 20 bytes → 16 bytes are stored, `load_err`=1, `words_loaded`=4, and `load_ready` stays 1 until `load_last`.
- With `START_PC`=0x100, load 1 word then fetch 0x100 → the loaded word. Fetch 0xFC → NOP.
- In RUN, hold `read_enable_cpu`=0 across 3 cycles while changing the address → `inst` unchanged. Then assert `halt` with a fetch on the same edge → `inst`=NOP and `go`=0; later fetches stay NOP.
- Assert `reset` after 3 bytes, then reload 4 new bytes → the first fetch returns the new word only, and `load_err`=0.
